// File: rtl/acc_result_reader_pkg.sv
// Shared types and default sizes for the accumulator result reader.
// The optional saturating narrower is selected with ACC_RESULT_READER_SAT_EN.
package acc_result_reader_pkg;

    localparam int DEF_SIZE       = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OUT_WIDTH  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/acc_narrow.sv
// Narrows one signed accumulator lane to the output element width.
// ACC_RESULT_READER_SAT_EN defined: clamp to the signed output range; otherwise truncate.
module acc_narrow
    import acc_result_reader_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic        [OUT_WIDTH-1:0] dout
);

`ifdef ACC_RESULT_READER_SAT_EN
    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Signed clamp into the representable output range
    always_comb begin
        if (din > MAX_V) begin
            dout = MAX_V[OUT_WIDTH-1:0];
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_WIDTH-1:0];
        end else begin
            dout = din[OUT_WIDTH-1:0];
        end
    end
`else
    logic unused_hi_s;

    assign unused_hi_s = ^{1'b0, din};

    // Plain truncation keeps the low-order bits
    always_comb begin
        dout = din[OUT_WIDTH-1:0];
    end
`endif

endmodule

// File: rtl/acc_result_reader.sv
// Captures a tile of accumulator lanes and streams lanes 0..depth over a valid/ready port.
// Narrowing mode is chosen by ACC_RESULT_READER_SAT_EN (see acc_narrow).
module acc_result_reader
    import acc_result_reader_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [DATA_WIDTH-1:0]   acc_data_i [0:SIZE-1],
    input  logic                           tile_calc_over_i,
    input  logic [$clog2(SIZE)-1:0]        valid_depth_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [OUT_WIDTH-1:0]           m_data_o,
    output logic [$clog2(SIZE)-1:0]        m_idx_o,
    output logic                           m_last_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    localparam int IDX_W = $clog2(SIZE);

    state_e                        state_r;
    logic [IDX_W-1:0]              idx_r;
    logic [IDX_W-1:0]              depth_r;
    logic                          last_r;
    logic [OUT_WIDTH-1:0]          data_r;
    logic                          overrun_r;
    logic signed [DATA_WIDTH-1:0]  bank_r [0:SIZE-1];

    logic                          xfer_s;
    logic                          last_xfer_s;
    logic                          capture_s;
    logic                          advance_s;
    logic [IDX_W-1:0]              idx_inc_s;
    logic signed [DATA_WIDTH-1:0]  lane_s;
    logic [OUT_WIDTH-1:0]          narrow_s;

    // Handshake decode; the narrower sees lane 0 of a fresh tile or the next banked lane
    always_comb begin
        xfer_s      = (state_r == STREAM) & m_ready_i;
        last_xfer_s = xfer_s & last_r;
        capture_s   = tile_calc_over_i & ((state_r == IDLE) | last_xfer_s);
        advance_s   = xfer_s & ~last_r;
        idx_inc_s   = idx_r + IDX_W'(1);
        if (capture_s) begin
            lane_s = acc_data_i[0];
        end else begin
            lane_s = bank_r[idx_inc_s];
        end
    end

    acc_narrow #(
        .IN_WIDTH  (DATA_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_narrow (
        .din  (lane_s),
        .dout (narrow_s)
    );

    // Capture bank holds the tile being drained; it carries no reset
    always_ff @(posedge clk) begin
        if (capture_s) begin
            bank_r <= acc_data_i;
        end
    end

    // Control FSM with registered element, index and last flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= {IDX_W{1'b0}};
            depth_r   <= {IDX_W{1'b0}};
            last_r    <= 1'b0;
            data_r    <= {OUT_WIDTH{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            // A new tile mid-stream is dropped unless it lands on the final transfer
            overrun_r <= tile_calc_over_i & (state_r == STREAM) & ~last_xfer_s;
            if (capture_s) begin
                state_r <= STREAM;
                idx_r   <= {IDX_W{1'b0}};
                depth_r <= valid_depth_i;
                last_r  <= (valid_depth_i == {IDX_W{1'b0}});
                data_r  <= narrow_s;
            end else if (last_xfer_s) begin
                state_r <= IDLE;
                last_r  <= 1'b0;
            end else if (advance_s) begin
                idx_r  <= idx_inc_s;
                last_r <= (idx_inc_s == depth_r);
                data_r <= narrow_s;
            end else begin
                state_r <= state_r;
                idx_r   <= idx_r;
                last_r  <= last_r;
                data_r  <= data_r;
            end
        end
    end

    assign m_valid_o = (state_r == STREAM);
    assign busy_o    = (state_r == STREAM);
    assign m_data_o  = data_r;
    assign m_idx_o   = idx_r;
    assign m_last_o  = last_r;
    assign overrun_o = overrun_r;

endmodule

// File: tb/tb_acc_result_reader.sv
// Directed bench for acc_result_reader: per-cycle check against a tile/queue model plus
// hand-computed expectations for the drain, stall, narrowing, overrun, back-to-back and reset cases.
module tb_acc_result_reader;

    localparam int SIZE = 16;
    localparam int DW   = 32;
    localparam int OW   = 8;
    localparam int IW   = $clog2(SIZE);

    typedef struct {
        int             idx;
        logic [OW-1:0]  data;
        bit             last;
        int             cyc;
    } beat_t;

    logic                   clk;
    logic                   rst_n;
    logic signed [DW-1:0]   acc_data [0:SIZE-1];
    logic                   tco;
    logic [IW-1:0]          vdepth;
    logic                   m_valid;
    logic                   m_ready;
    logic [OW-1:0]          m_data;
    logic [IW-1:0]          m_idx;
    logic                   m_last;
    logic                   busy;
    logic                   overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ovr_cnt = 0;
    beat_t log_q[$];

    // Model state: the tile being drained and the position reached
    bit                     md_act = 1'b0;
    logic signed [DW-1:0]   md_tile [0:SIZE-1];
    int                     md_depth = 0;
    int                     md_pos = 0;
    bit                     md_ovr = 1'b0;

    acc_result_reader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .acc_data_i       (acc_data),
        .tile_calc_over_i (tco),
        .valid_depth_i    (vdepth),
        .m_valid_o        (m_valid),
        .m_ready_i        (m_ready),
        .m_data_o         (m_data),
        .m_idx_o          (m_idx),
        .m_last_o         (m_last),
        .busy_o           (busy),
        .overrun_o        (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [OW-1:0] nar(input logic signed [DW-1:0] v);
        longint x;
        longint lim;
        x   = longint'(v);
        lim = longint'(1) << (OW - 1);
`ifdef ACC_RESULT_READER_SAT_EN
        if (x > lim - 1) return OW'(lim - 1);
        if (x < -lim) return OW'(-lim);
`endif
        return OW'(x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_tile(input int depth, input int base, input int stride);
        for (int i = 0; i < SIZE; i++) acc_data[i] = base + stride * i;
        vdepth = IW'(depth);
        tco = 1'b1;
        step();
        tco = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (!busy) break;
            step();
        end
        chk("drain_timeout", busy, 0);
    endtask

    task automatic wait_beat(input int idx, input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (m_valid && m_idx == IW'(idx)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_beat_timeout", found, 1);
    endtask

    // Reference model: advance one clock using the specified tile/handshake rules
    initial begin
        forever begin
            bit fin;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                md_act = 1'b0;
                md_pos = 0;
                md_ovr = 1'b0;
            end else begin
                fin    = md_act && m_ready && (md_pos == md_depth);
                md_ovr = md_act && tco && !fin;
                if (tco && (!md_act || fin)) begin
                    md_tile  = acc_data;
                    md_depth = int'(vdepth);
                    md_pos   = 0;
                    md_act   = 1'b1;
                end else if (fin) begin
                    md_act = 1'b0;
                end else if (md_act && m_ready) begin
                    md_pos++;
                end
            end
        end
    end

    // Per-cycle compare and transfer log
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (overrun) ovr_cnt++;
            chk("valid", m_valid, md_act);
            chk("busy", busy, md_act);
            chk("overrun", overrun, md_ovr);
            if (md_act) begin
                chk("idx", m_idx, md_pos);
                chk("data", m_data, nar(md_tile[md_pos]));
                chk("last", m_last, md_pos == md_depth);
            end
            if (rst_n && m_valid && m_ready) log_q.push_back('{int'(m_idx), m_data, m_last, cyc});
        end
    end

    initial begin
        bit pat [0:3];
        logic [OW-1:0] exp_nar [0:2];
        int ovr0;
        int exp_d [0:4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
`ifdef ACC_RESULT_READER_SAT_EN
        exp_nar = '{8'd127, 8'd128, 8'd251};
`else
        exp_nar = '{8'd44, 8'd56, 8'd251};
`endif
        exp_d = '{50, 51, 70, 71, 72};

        rst_n = 1'b0;
        tco = 1'b0;
        m_ready = 1'b0;
        vdepth = '0;
        for (int i = 0; i < SIZE; i++) acc_data[i] = '0;
        #1;
        chk("reset_valid", m_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_data", m_data, 0);
        chk("reset_idx", m_idx, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Full-depth tile with ready held high (ready while idle has no effect)
        m_ready = 1'b1;
        step();
        log_q.delete();
        load_tile(15, 0, 1);
        wait_idle(40);
        chk("full_beats", log_q.size(), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            chk("full_idx", log_q[i].idx, i);
            chk("full_data", log_q[i].data, i);
            chk("full_last", log_q[i].last, i == 15);
            chk("full_consec", log_q[i].cyc - log_q[0].cyc, i);
        end

        // Depth 3 with ready toggling 1,0,0,1
        log_q.delete();
        load_tile(3, 1, 10);
        for (int k = 0; k < 40; k++) begin
            m_ready = pat[k % 4];
            step();
            if (!busy) break;
        end
        m_ready = 1'b1;
        wait_idle(10);
        chk("stall_beats", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("stall_idx", log_q[i].idx, i);
            chk("stall_data", log_q[i].data, 10 * i + 1);
        end

        // Narrowing of out-of-range and negative lanes
        log_q.delete();
        for (int i = 0; i < SIZE; i++) acc_data[i] = '0;
        acc_data[0] = 300;
        acc_data[1] = -200;
        acc_data[2] = -5;
        vdepth = IW'(2);
        tco = 1'b1;
        step();
        tco = 1'b0;
        wait_idle(10);
        chk("narrow_beats", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) chk("narrow_data", log_q[i].data, exp_nar[i]);

        // Second tile arriving at idx 2 of a depth-7 tile is dropped
        log_q.delete();
        ovr0 = ovr_cnt;
        load_tile(7, 100, 1);
        wait_beat(2, 20);
        for (int i = 0; i < SIZE; i++) acc_data[i] = 900 + i;
        vdepth = IW'(3);
        tco = 1'b1;
        step();
        tco = 1'b0;
        wait_idle(20);
        step();
        step();
        chk("ovr_pulses", ovr_cnt - ovr0, 1);
        chk("ovr_beats", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) chk("ovr_data", log_q[i].data, 100 + i);
        chk("ovr_discard_busy", busy, 0);

        // New tile coincident with the final transfer: no bubble, no overrun
        log_q.delete();
        ovr0 = ovr_cnt;
        load_tile(1, 50, 1);
        for (int k = 0; k < 10; k++) begin
            if (m_valid && m_last) break;
            step();
        end
        load_tile(2, 70, 1);
        wait_idle(20);
        chk("b2b_ovr", ovr_cnt - ovr0, 0);
        chk("b2b_beats", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk("b2b_data", log_q[i].data, exp_d[i]);
            chk("b2b_consec", log_q[i].cyc - log_q[0].cyc, i);
        end

        // Reset in the middle of a tile
        load_tile(15, 200, 1);
        wait_beat(5, 20);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_data", m_data, 0);
        chk("rst_idx", m_idx, 0);
        step();
        step();
        rst_n = 1'b1;
        log_q.delete();
        for (int k = 0; k < 6; k++) step();
        chk("post_rst_beats", log_q.size(), 0);
        chk("post_rst_valid", m_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
